bundled_to_sync: RTL and testbench

BUNDLED_TO_SYNC -- requirements
Module: bundled_to_sync

---
 rtl/bundled_to_sync_if.sv | 36 +++
 rtl/bundled_to_sync.sv | 95 +++++++++
 tb/tb_bundled_to_sync.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bundled_to_sync_if.sv
// Handshake and stream bundle between an upstream 4-phase latch micropipeline,
// the bundled_to_sync bridge and a synchronous valid/ready consumer.
// The bridge connects through the slave modport. The environment connects
// through the master modport, which drives the request side and the consumer ready.
interface bundled_to_sync_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                     a_req;
    logic [DATA_W-1:0]        a_data;
    logic                     a_ack;
    logic                     s_valid;
    logic [DATA_W-1:0]        s_data;
    logic                     s_ready;
    logic [$clog2(DEPTH):0]   level;

    modport master (
        output a_req,
        output a_data,
        input  a_ack,
        input  s_valid,
        input  s_data,
        output s_ready,
        input  level
    );

    modport slave (
        input  a_req,
        input  a_data,
        output a_ack,
        output s_valid,
        output s_data,
        input  s_ready,
        output level
    );
endinterface

// File: rtl/bundled_to_sync.sv
// Bridge from a 4-phase bundled-data micropipeline into a synchronous
// valid/ready stream.
// The request is synchronized into clk, and a two-state FSM drives the acknowledge.
// Each accepted request writes the bundled word into a small circular FIFO.
// The FIFO keeps the full request when it has no room, which back-pressures upstream.
module bundled_to_sync #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEPTH       = 4
) (
    input  logic                clk,
    input  logic                reset_i_n,
    bundled_to_sync_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    state_t                 state;

    logic [DATA_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [LVL_W-1:0]       level_q;

    logic                   full;
    logic                   push;
    logic                   pop;

    assign req_s = sync_q[SYNC_STAGES-1];
    assign full  = (level_q == LVL_W'(DEPTH));
    // Full is judged on the pre-edge level, so a same-cycle pop never makes room for a write.
    assign push  = (state == IDLE) && req_s && !full;
    // Pop is gated by occupancy, so s_ready is ignored while the FIFO is empty.
    assign pop   = (level_q != '0) && bus.s_ready;

    // The request synchronizer is the only logic that samples the asynchronous a_req.
    always_ff @(posedge clk or negedge reset_i_n) begin
        if (!reset_i_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.a_req};
        end
    end

    // Handshake FSM: raise ack together with the FIFO write, and drop ack once the request has fallen.
    always_ff @(posedge clk or negedge reset_i_n) begin
        if (!reset_i_n) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    if (push)   state <= ACKED;
                ACKED:   if (!req_s) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Circular FIFO storage, pointers and occupancy; a push and a pop on the same edge leave the level unchanged.
    always_ff @(posedge clk or negedge reset_i_n) begin
        if (!reset_i_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= bus.a_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // a_ack is the one-bit state flop itself, so it cannot glitch.
    assign bus.a_ack   = (state == ACKED);
    assign bus.s_valid = (level_q != '0);
    assign bus.s_data  = mem[rd_ptr];
    assign bus.level   = level_q;
endmodule

// File: tb/tb_bundled_to_sync.sv
// Scoreboard bench for bundled_to_sync.
// The stimulus tasks queue each word as they issue its handshake.
// A monitor pops the queue and compares whenever the consumer takes a word.
// Protocol watchers check the a_ack phases and the level/valid invariants.
module tb_bundled_to_sync;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int SYNC   = 2;
    localparam int BOUND  = 200;

    logic clk;
    logic reset_i_n;
    bit   run_checks;
    bit   rand_done;
    int   n_checks;
    int   n_fail;

    logic [DATA_W-1:0] exp_q [$];

    bundled_to_sync_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    bundled_to_sync #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC),
        .DEPTH       (DEPTH)
    ) dut (
        .clk       (clk),
        .reset_i_n (reset_i_n),
        .bus       (bus)
    );

    // Free-running consumer-domain clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Raise a request with a fresh word, record the expected word, and wait for the ack.
    task automatic raise_req(input logic [DATA_W-1:0] word, input int delay);
        int cnt;
        if (delay > 0) #(delay);
        bus.a_data = word;
        bus.a_req  = 1'b1;
        exp_q.push_back(word);
        cnt = 0;
        while (!bus.a_ack && cnt < BOUND) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!bus.a_ack) checkOutput("ack_rise_timeout", bus.a_ack, 1);
    endtask

    // Drop the request and wait for the ack to return low.
    task automatic drop_req();
        int cnt;
        bus.a_req = 1'b0;
        cnt = 0;
        while (bus.a_ack && cnt < BOUND) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (bus.a_ack) checkOutput("ack_fall_timeout", bus.a_ack, 0);
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word, input int delay);
        raise_req(word, delay);
        drop_req();
    endtask

    // Empty the FIFO through the consumer and confirm every queued word was seen.
    task automatic drain_fifo();
        int cnt;
        @(posedge clk); #1;
        bus.s_ready = 1'b1;
        cnt = 0;
        while (bus.level != 0 && cnt < BOUND) begin
            @(posedge clk); #1;
            cnt++;
        end
        bus.s_ready = 1'b0;
        checkOutput("drain_level", bus.level, 0);
        checkOutput("scoreboard_empty", exp_q.size(), 0);
    endtask

    // Scoreboard monitor: a word is consumed on the next edge whenever valid and ready are both high.
    always @(negedge clk) begin
        if (run_checks && reset_i_n) begin
            checkOutput("valid_vs_level", bus.s_valid, (bus.level != 0));
            checkOutput("level_bound", (bus.level <= DEPTH), 1);
            if (bus.s_valid && bus.s_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL pop_unexpected: got 0x%0h, expected no word", bus.s_data);
                end else begin
                    checkOutput("pop_data", bus.s_data, exp_q.pop_front());
                end
            end
        end
    end

    // Protocol watcher: ack may rise only while the request is high, and fall only after the request is low.
    always @(posedge bus.a_ack) begin
        if (run_checks && reset_i_n) checkOutput("ack_rise_phase", bus.a_req, 1);
    end

    always @(negedge bus.a_ack) begin
        if (run_checks && reset_i_n) checkOutput("ack_fall_phase", bus.a_req, 0);
    end

    // Global time limit so the bench always ends.
    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Directed test sequence.
    initial begin
        int edges;
        n_checks    = 0;
        n_fail      = 0;
        run_checks  = 1'b0;
        rand_done   = 1'b0;
        reset_i_n   = 1'b0;
        bus.a_req   = 1'b0;
        bus.a_data  = '0;
        bus.s_ready = 1'b0;

        #3;
        checkOutput("reset_ack", bus.a_ack, 0);
        checkOutput("reset_valid", bus.s_valid, 0);
        checkOutput("reset_level", bus.level, 0);
        checkOutput("reset_data", bus.s_data, 0);

        repeat (2) @(posedge clk);
        #1 reset_i_n = 1'b1;
        run_checks = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_after_release", bus.level, 0);
        checkOutput("noack_after_release", bus.a_ack, 0);

        // Single transfer with the latency counted in edges.
        $display("[TB] single transfer");
        bus.s_ready = 1'b1;
        bus.a_data  = 8'hA5;
        bus.a_req   = 1'b1;
        exp_q.push_back(8'hA5);
        edges = 0;
        while (!bus.a_ack && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("ack_rise_latency", edges, SYNC + 1);
        checkOutput("valid_with_ack", bus.s_valid, 1);
        checkOutput("head_a5", bus.s_data, 8'hA5);
        checkOutput("level_one", bus.level, 1);
        @(posedge clk); #1;
        checkOutput("valid_one_cycle", bus.s_valid, 0);
        checkOutput("level_back_zero", bus.level, 0);
        bus.a_req = 1'b0;
        edges = 0;
        while (bus.a_ack && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        checkOutput("ack_fall_latency", edges, SYNC + 1);
        bus.s_ready = 1'b0;

        // Fill to full, then hold the fifth request until one word is popped.
        $display("[TB] fill and back-pressure");
        for (int i = 1; i <= 4; i++) applyStimulus(DATA_W'(i), 0);
        checkOutput("level_full", bus.level, 4);
        checkOutput("head_01", bus.s_data, 8'h01);
        fork
            applyStimulus(8'h05, 0);
            begin
                repeat (8) @(posedge clk);
                #1;
                checkOutput("backpressure_ack", bus.a_ack, 0);
                checkOutput("backpressure_level", bus.level, 4);
                bus.s_ready = 1'b1;
                @(posedge clk); #1;
                bus.s_ready = 1'b0;
                checkOutput("after_pop_level", bus.level, 3);
                @(posedge clk); #1;
                checkOutput("refill_level", bus.level, 4);
                checkOutput("refill_ack", bus.a_ack, 1);
                checkOutput("head_02", bus.s_data, 8'h02);
            end
        join
        drain_fifo();

        // Ten back-to-back words wrap both pointers more than once.
        $display("[TB] pointer wrap");
        bus.s_ready = 1'b1;
        for (int i = 0; i < 10; i++) applyStimulus(8'h10 + DATA_W'(i), 0);
        drain_fifo();

        // Level 2, then a write and a pop land on the same edge.
        $display("[TB] simultaneous push and pop");
        applyStimulus(8'h21, 0);
        applyStimulus(8'h22, 0);
        checkOutput("sim_level_two", bus.level, 2);
        checkOutput("sim_head_21", bus.s_data, 8'h21);
        @(posedge clk); #1;
        fork
            applyStimulus(8'h23, 0);
            begin
                repeat (2) @(posedge clk);
                #1 bus.s_ready = 1'b1;
                @(posedge clk); #1;
                bus.s_ready = 1'b0;
                checkOutput("sim_level_kept", bus.level, 2);
                checkOutput("sim_ack_same_edge", bus.a_ack, 1);
                checkOutput("sim_head_22", bus.s_data, 8'h22);
            end
        join
        drain_fifo();

        // Reset while three words are stored and the ack is high.
        $display("[TB] reset mid-operation");
        applyStimulus(8'h31, 0);
        applyStimulus(8'h32, 0);
        raise_req(8'h33, 0);
        checkOutput("pre_reset_level", bus.level, 3);
        checkOutput("pre_reset_ack", bus.a_ack, 1);
        @(negedge clk);
        #1 bus.a_req = 1'b0;
        #1 reset_i_n = 1'b0;
        #1;
        checkOutput("async_reset_ack", bus.a_ack, 0);
        checkOutput("async_reset_valid", bus.s_valid, 0);
        checkOutput("async_reset_level", bus.level, 0);
        exp_q.delete();
        @(posedge clk); #1;
        reset_i_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("post_reset_level", bus.level, 0);
        applyStimulus(8'h3C, 0);
        checkOutput("post_reset_head", bus.s_data, 8'h3C);
        checkOutput("post_reset_only_word", bus.level, 1);
        drain_fifo();

        // Randomized request timing against a randomly stalling consumer.
        $display("[TB] randomized protocol");
        fork
            begin
                for (int i = 0; i < 12; i++) applyStimulus(8'h40 + DATA_W'(i), int'($urandom_range(1, 23)));
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    bus.s_ready = 1'($urandom_range(0, 1));
                end
                bus.s_ready = 1'b0;
            end
        join
        drain_fifo();

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
